link_serializer: RTL and testbench
==================================

Name: link_serializer

Overview:
Parametrised serial link transmitter with a word FIFO, configurable word width, bit order and optional even-parity bit.
- Accepts parallel words over a valid/ready handshake and buffers up to FIFO_DEPTH of them.
- Shifts each frame out on S_OUT, one bit per LINK_CLK, with no gap between frames while the FIFO has data.
- Pulses SYNC on each frame's final bit.
- Sits between game-logic data producers and the inter-board link pins; it is the drop-in successor to the fixed 16-bit single-buffer link transmitter.

Parameters:
- DATA_W, 16, payload bits per frame (2..32).
- FIFO_DEPTH, 4, word FIFO entries (power of two, >=2).
- INIT_CYCLES, 16, post-reset quiet cycles before the first transmission (>=1).
- PARITY_EN, 1, 1 = append even-parity bit after payload; 0 = none.
- MSB_FIRST, 1, 1 = bit DATA_W-1 sent first; 0 = bit 0 first.

Ports:
- LINK_CLK  input  1  link clock, all logic on rising edge.
- RESETN  input  1  asynchronous active-low reset.
- DATA_VALID  input  1  producer has a word on TR_DATA.
- TR_DATA  input  DATA_W  word to transmit.
- TR_READY  output  1  push accepted this cycle when DATA_VALID & TR_READY.
- S_OUT  output  1  serial data, registered.
- SYNC  output  1  one-cycle pulse, registered, aligned with a frame's last bit on S_OUT.
- BUSY  output  1  high while a frame is being shifted.
- FIFO_LEVEL  output  $clog2(FIFO_DEPTH+1)  words currently buffered.

Behaviour:
- Reset is asynchronous on RESETN low. Required values:
  - S_OUT=0, SYNC=0, BUSY=0, FIFO_LEVEL=0, TR_READY=0.
  - FIFO contents discarded; state=INIT; counters=0.
- Frame length FL = DATA_W + PARITY_EN. Parity bit = XOR of all payload bits (even parity).
- TR_READY = (state != INIT) & (FIFO not full).
  - A push while full is ignored (TR_READY=0).
  - There is no push/pop bypass: a pop in the same cycle does not free space for a push.
- State INIT:
  - S_OUT=0.
  - Counts INIT_CYCLES cycles, then moves to IDLE.
  - TR_READY=0 throughout.
- State IDLE:
  - S_OUT=0, BUSY=0.
  - If the FIFO is non-empty, pop the head into the shift register and go to SHIFT.
  - The FIFO does not fall through: a word pushed at edge t can be popped at the earliest at edge t+1.
- State SHIFT:
  - Popped at edge t, the first bit is visible on S_OUT after edge t+1. Bit k is visible after edge t+1+k, k=0..FL-1.
  - BUSY=1 from edge t+1 through the last bit.
  - SYNC=1 only during the cycle S_OUT carries bit FL-1.
- End of frame:
  - At the edge that drives the last bit, if the FIFO is non-empty, pop the next word; its bit 0 follows immediately (gapless, BUSY stays 1).
  - Otherwise return to IDLE; S_OUT returns to 0 at the next edge.
- Bit counter width is $clog2(FL); it is compared to FL-1, never wrapped implicitly.
- FIFO_LEVEL changes by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
- Reset asserted mid-frame aborts the frame immediately:
  - No SYNC is issued and partial bits are not resent.
  - INIT re-runs after RESETN deassertion.
- DATA_VALID may drop without a handshake; TR_DATA is sampled only on an accepted push.

Decomposition:
- Package link_pkg:
  - State encoding INIT/IDLE/SHIFT.
  - Default DATA_W, FIFO_DEPTH and INIT_CYCLES constants.
  - A parity function.
- Sub-module link_sync_fifo: DATA_W × FIFO_DEPTH synchronous FIFO with full, empty and level outputs, same clock and reset.
- The serializer FSM, shift register and counters stay in link_serializer.

Test Plan:
- Reset/init: release RESETN, hold DATA_VALID=1 -> TR_READY=0 and S_OUT=0 for 16 cycles; TR_READY=1 on cycle 17.
- Single word with defaults: push 16'h8001 -> S_OUT = 1,0×14,1, then parity 0.
  - SYNC high only on the parity cycle; BUSY high exactly 17 cycles; S_OUT=0 afterwards.
- Parity/order: push 16'h0001 -> 15 zeros, 1, then parity 1.
  - With MSB_FIRST=0, the same word gives 1, 15 zeros, parity 1.
- Back-to-back: push 16'hA5C3, 16'h0F0F, 16'hFFFF on consecutive cycles -> 51 contiguous bits.
  - SYNC at bit offsets 16, 33 and 50; BUSY never drops.
- FIFO full: push 6 words on consecutive cycles from IDLE -> first word popped, FIFO_LEVEL reaches 4, TR_READY=0 on the 6th cycle.
  - The 6th word is not accepted; it is accepted once the first frame ends.
- Mid-frame reset: assert RESETN at bit 7 of a frame -> S_OUT=0, SYNC=0, FIFO_LEVEL=0 immediately.
  - INIT re-runs; no residual bits are transmitted afterwards.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: shared state encoding, default sizing and parity helper for the serial link transmitter
//   DEF_* constants are the drop-in defaults matching the legacy 16-bit link.
//   even_parity(): XOR-reduce of a zero-extended payload (even parity).
package link_pkg;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT} state_e;

   localparam int DEF_DATA_W      = 16;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int DEF_INIT_CYCLES = 16;
   localparam int MAX_DATA_W      = 32;

   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/link_sync_fifo.sv
// link_sync_fifo: DATA_W x DEPTH synchronous word FIFO, head word visible on rdata_o
//   LINK_CLK/RESETN : clock, asynchronous active-low reset (discards contents)
//   push_i/wdata_i  : write a word (ignored while full)
//   pop_i/rdata_o   : drop the head word (ignored while empty); rdata_o is the head
//   full_o/empty_o/level_o : occupancy flags and word count
module link_sync_fifo
   import link_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_FIFO_DEPTH,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = $clog2(DEPTH + 1)
) (
   input  logic              LINK_CLK,
   input  logic              RESETN,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [LW-1:0]     level_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [LW-1:0]     level_q;
   logic              push_en, pop_en;

   assign full_o  = level_q == LW'(DEPTH);
   assign empty_o = level_q == '0;
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_q];
   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge LINK_CLK or negedge RESETN) begin
      if (!RESETN) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push_en) wr_q <= wr_q + AW'(1);
         if (pop_en) rd_q <= rd_q + AW'(1);
         level_q <= level_q + LW'(push_en) - LW'(pop_en);
      end
   end

   always_ff @(posedge LINK_CLK) begin
      if (push_en) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/link_serializer.sv
// link_serializer: buffered serial link transmitter, gapless frames with optional even parity
//   LINK_CLK/RESETN       : clock, asynchronous active-low reset
//   DATA_VALID/TR_DATA    : producer word; accepted when TR_READY is also high
//   TR_READY              : not in post-reset quiet period and FIFO not full
//   S_OUT/SYNC/BUSY       : registered serial bit, last-bit pulse, frame-in-progress
//   FIFO_LEVEL            : words buffered
module link_serializer
   import link_pkg::*;
#(
   parameter  int DATA_W      = DEF_DATA_W,
   parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter  int INIT_CYCLES = DEF_INIT_CYCLES,
   parameter  int PARITY_EN   = 1,
   parameter  int MSB_FIRST   = 1,
   localparam int FL          = DATA_W + PARITY_EN,
   localparam int CW          = $clog2(FL),
   localparam int IW          = $clog2(INIT_CYCLES + 1),
   localparam int LW          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              LINK_CLK,
   input  logic              RESETN,
   input  logic              DATA_VALID,
   input  logic [DATA_W-1:0] TR_DATA,
   output logic              TR_READY,
   output logic              S_OUT,
   output logic              SYNC,
   output logic              BUSY,
   output logic [LW-1:0]     FIFO_LEVEL
);

   state_e            state_q, state_d;
   logic [IW-1:0]     init_q, init_d;
   logic [CW-1:0]     bit_q, bit_d;
   logic [FL-1:0]     shreg_q, shreg_d, frame;
   logic              s_out_q, s_out_d, sync_q, sync_d, busy_q, busy_d;
   logic [DATA_W-1:0] head;
   logic              full, empty, pop, last;

   assign TR_READY   = (state_q != ST_INIT) & ~full;
   assign S_OUT      = s_out_q;
   assign SYNC       = sync_q;
   assign BUSY       = busy_q;
   assign last       = bit_q == CW'(FL - 1);

   link_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .LINK_CLK (LINK_CLK),
      .RESETN   (RESETN),
      .push_i   (DATA_VALID & TR_READY),
      .wdata_i  (TR_DATA),
      .pop_i    (pop),
      .rdata_o  (head),
      .full_o   (full),
      .empty_o  (empty),
      .level_o  (FIFO_LEVEL)
   );

   // frame[k] is the k-th bit on the wire, so the shifter always emits bit 0
   always_comb begin
      frame = '0;
      for (int k = 0; k < DATA_W; k++) frame[k] = (MSB_FIRST != 0) ? head[DATA_W-1-k] : head[k];
      if (PARITY_EN != 0) frame[FL-1] = even_parity(MAX_DATA_W'(head));
   end

   always_ff @(posedge LINK_CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= ST_INIT;
         init_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         s_out_q <= 1'b0;
         sync_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         s_out_q <= s_out_d;
         sync_q  <= sync_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      init_d  = init_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      s_out_d = 1'b0;
      sync_d  = 1'b0;
      busy_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_d  = init_q + IW'(1);
            state_d = (init_q == IW'(INIT_CYCLES - 1)) ? ST_IDLE : ST_INIT;
         end
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shreg_d = frame;
               bit_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            s_out_d = shreg_q[0];
            busy_d  = 1'b1;
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + CW'(1);
            // on the last bit, reload straight from the FIFO head to stay gapless
            if (last) begin
               sync_d  = 1'b1;
               bit_d   = '0;
               pop     = ~empty;
               shreg_d = empty ? shreg_q >> 1 : frame;
               state_d = empty ? ST_IDLE : ST_SHIFT;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_link_serializer.sv
module tb_link_serializer;

   localparam int INIT  = 16;
   localparam int DEPTH = 4;

   logic        LINK_CLK = 1'b0;
   logic        RESETN = 1'b1;
   logic        DATA_VALID = 1'b0;
   logic [15:0] TR_DATA = '0;
   logic        ready_m, sout_m, sync_m, busy_m, ready_l, sout_l, sync_l, busy_l;
   logic [2:0]  lvl_m, lvl_l;

   int vectors = 0;
   int errors = 0;
   bit mon_en = 0;

   always #5 LINK_CLK = ~LINK_CLK;

   link_serializer u_msb (
      .LINK_CLK(LINK_CLK), .RESETN(RESETN), .DATA_VALID(DATA_VALID), .TR_DATA(TR_DATA),
      .TR_READY(ready_m), .S_OUT(sout_m), .SYNC(sync_m), .BUSY(busy_m), .FIFO_LEVEL(lvl_m)
   );

   link_serializer #(.MSB_FIRST(0)) u_lsb (
      .LINK_CLK(LINK_CLK), .RESETN(RESETN), .DATA_VALID(DATA_VALID), .TR_DATA(TR_DATA),
      .TR_READY(ready_l), .S_OUT(sout_l), .SYNC(sync_l), .BUSY(busy_l), .FIFO_LEVEL(lvl_l)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: a word queue plus the remaining wire bits of the frame in flight
   int          m_init = INIT;
   logic [15:0] m_q[$];
   bit          m_cm[$], m_cl[$];
   bit          m_sout = 0, m_lout = 0, m_sync = 0, m_busy = 0, m_ready = 0, m_acc = 0;
   int          m_level = 0;

   task automatic load(input logic [15:0] d);
      for (int k = 0; k < 16; k++) begin
         m_cm.push_back(d[15-k]);
         m_cl.push_back(d[k]);
      end
      m_cm.push_back(^d);
      m_cl.push_back(^d);
   endtask

   always @(posedge LINK_CLK or negedge RESETN) begin
      if (!RESETN) begin
         m_init = INIT; m_q.delete(); m_cm.delete(); m_cl.delete();
         m_sout = 0; m_lout = 0; m_sync = 0; m_busy = 0; m_ready = 0; m_level = 0;
      end else begin
         m_acc = DATA_VALID && m_init == 0 && m_q.size() < DEPTH;
         if (m_init > 0) begin
            m_init--;
            m_sout = 0; m_lout = 0; m_sync = 0; m_busy = 0;
         end else if (m_cm.size() > 0) begin
            m_sout = m_cm.pop_front();
            m_lout = m_cl.pop_front();
            m_sync = m_cm.size() == 0;
            m_busy = 1;
            if (m_cm.size() == 0 && m_q.size() > 0) load(m_q.pop_front());
         end else begin
            m_sout = 0; m_lout = 0; m_sync = 0; m_busy = 0;
            if (m_q.size() > 0) load(m_q.pop_front());
         end
         if (m_acc) m_q.push_back(TR_DATA);
         m_ready = m_init == 0 && m_q.size() < DEPTH;
         m_level = m_q.size();
      end
   end

   always @(negedge LINK_CLK) begin
      if (mon_en) begin
         chk("sout_msb", 64'(sout_m), 64'(m_sout));
         chk("sync_msb", 64'(sync_m), 64'(m_sync));
         chk("busy_msb", 64'(busy_m), 64'(m_busy));
         chk("level_msb", 64'(lvl_m), 64'(m_level));
         chk("ready_msb", 64'(ready_m), 64'(m_ready));
         chk("sout_lsb", 64'(sout_l), 64'(m_lout));
         chk("sync_lsb", 64'(sync_l), 64'(m_sync));
         chk("busy_lsb", 64'(busy_l), 64'(m_busy));
         chk("level_lsb", 64'(lvl_l), 64'(m_level));
         chk("ready_lsb", 64'(ready_l), 64'(m_ready));
      end
   end

   task automatic capture(input int n, output logic [63:0] vm, output logic [63:0] vl,
                          output logic [63:0] sm, output logic [63:0] bm);
      vm = '0; vl = '0; sm = '0; bm = '0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge LINK_CLK);
         vm = {vm[62:0], sout_m};
         vl = {vl[62:0], sout_l};
         sm = {sm[62:0], sync_m};
         bm = {bm[62:0], busy_m};
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(m_q.size() == 0 && m_cm.size() == 0 && !m_busy) && n < 400) begin
         @(negedge LINK_CLK);
         n++;
      end
      chk("idle_reached", 64'(n < 400), 64'(1));
   endtask

   typedef struct packed {
      logic [15:0] data;
      logic [16:0] em;
      logic [16:0] el;
   } vec_t;

   vec_t        tbl [5];
   logic [63:0] vm, vl, sm, bm;
   logic [15:0] w [6];
   int          cnt, ones, thr;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      // expected wire sequence, first bit at bit 16, parity last
      tbl[0] = '{16'h8001, 17'h10002, 17'h10002};
      tbl[1] = '{16'h0001, 17'h00003, 17'h10001};
      tbl[2] = '{16'hA5C3, 17'h14B86, 17'h1874A};
      tbl[3] = '{16'h0F0F, 17'h01E1E, 17'h1E1E0};
      tbl[4] = '{16'hFFFF, 17'h1FFFE, 17'h1FFFE};

      #1 RESETN = 1'b0;
      mon_en = 1;
      DATA_VALID = 1'b1;
      TR_DATA = 16'h1234;
      repeat (3) @(negedge LINK_CLK);
      chk("rst_sout", 64'(sout_m), 64'(0));
      chk("rst_level", 64'(lvl_m), 64'(0));
      chk("rst_ready", 64'(ready_m), 64'(0));
      RESETN = 1'b1;
      #1;
      chk("init_ready_c1", 64'(ready_m), 64'(0));
      for (int c = 2; c <= 16; c++) begin
         @(negedge LINK_CLK);
         chk("init_ready", 64'(ready_m), 64'(0));
         chk("init_sout", 64'(sout_m), 64'(0));
      end
      @(negedge LINK_CLK);
      chk("init_ready_c17", 64'(ready_m), 64'(1));
      DATA_VALID = 1'b0;

      for (int r = 0; r < 5; r++) begin
         wait_idle();
         DATA_VALID = 1'b1;
         TR_DATA = tbl[r].data;
         @(negedge LINK_CLK);
         DATA_VALID = 1'b0;
         repeat (2) @(negedge LINK_CLK);
         capture(17, vm, vl, sm, bm);
         chk($sformatf("frame_msb_%0d", r), vm, 64'(tbl[r].em));
         chk($sformatf("frame_lsb_%0d", r), vl, 64'(tbl[r].el));
         chk($sformatf("sync_pos_%0d", r), sm, 64'h1);
         chk($sformatf("busy_span_%0d", r), bm, 64'h1FFFF);
         @(negedge LINK_CLK);
         chk($sformatf("busy_after_%0d", r), 64'(busy_m), 64'(0));
         chk($sformatf("sout_after_%0d", r), 64'(sout_m), 64'(0));
      end

      wait_idle();
      for (int i = 2; i < 5; i++) begin
         DATA_VALID = 1'b1;
         TR_DATA = tbl[i].data;
         @(negedge LINK_CLK);
      end
      DATA_VALID = 1'b0;
      capture(51, vm, vl, sm, bm);
      chk("b2b_msb", vm, 64'({tbl[2].em, tbl[3].em, tbl[4].em}));
      chk("b2b_lsb", vl, 64'({tbl[2].el, tbl[3].el, tbl[4].el}));
      chk("b2b_sync", sm, 64'h0000_0004_0002_0001);
      chk("b2b_busy", bm, 64'h0007_FFFF_FFFF_FFFF);

      wait_idle();
      for (int i = 0; i < 6; i++) w[i] = 16'h1111 * 16'(i + 1);
      for (int i = 0; i < 5; i++) begin
         DATA_VALID = 1'b1;
         TR_DATA = w[i];
         @(negedge LINK_CLK);
      end
      TR_DATA = w[5];
      chk("full_level", 64'(lvl_m), 64'(4));
      chk("full_ready", 64'(ready_m), 64'(0));
      cnt = 0;
      while (!ready_m && cnt < 40) begin
         @(negedge LINK_CLK);
         cnt++;
      end
      chk("full_wait", 64'(cnt), 64'(14));
      @(negedge LINK_CLK);
      DATA_VALID = 1'b0;
      chk("full_6th_level", 64'(lvl_m), 64'(4));
      wait_idle();

      DATA_VALID = 1'b1;
      TR_DATA = 16'hFFFF;
      @(negedge LINK_CLK);
      TR_DATA = 16'h00FF;
      @(negedge LINK_CLK);
      DATA_VALID = 1'b0;
      repeat (8) @(negedge LINK_CLK);
      chk("bit7_before_reset", 64'(sout_m), 64'(1));
      #2 RESETN = 1'b0;
      #1;
      chk("mid_rst_sout", 64'(sout_m), 64'(0));
      chk("mid_rst_sync", 64'(sync_m), 64'(0));
      chk("mid_rst_level", 64'(lvl_m), 64'(0));
      chk("mid_rst_busy", 64'(busy_m), 64'(0));
      chk("mid_rst_sout_lsb", 64'(sout_l), 64'(0));
      repeat (2) @(negedge LINK_CLK);
      RESETN = 1'b1;
      ones = 0;
      repeat (40) begin
         @(negedge LINK_CLK);
         ones += int'(sout_m) + int'(sout_l) + int'(sync_m);
      end
      chk("residual_ones", 64'(ones), 64'(0));

      thr = 8;
      for (int c = 0; c < 1500; c++) begin
         if (c % 150 == 0) thr = $urandom_range(0, 16);
         DATA_VALID = $urandom_range(0, 15) < thr;
         TR_DATA = 16'($urandom);
         @(negedge LINK_CLK);
      end
      DATA_VALID = 1'b0;
      wait_idle();
      @(negedge LINK_CLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
